// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch sequencer sitting between an external PC register, a
// single-outstanding-request instruction memory and the decode stage.
//
// The unit issues one read at the current PC and waits for the memory ack.
// On the ack it captures the returned word for decode and bumps the PC by
// PC_STEP. It then holds that word until decode accepts it. A redirect
// (branch/jump) reloads the PC at once and squashes whatever is in flight or
// held.
//
// Ports
//   clk            : clock, rising-edge active
//   rst            : asynchronous active-high reset (also resets the memory)
//   pc_in          : current PC, taken from the external PC register output
//   pc_next        : value the PC register loads when pc_load=1 (0 otherwise)
//   pc_load        : PC register load strobe
//   imem_req       : instruction-memory read request
//   imem_addr      : read address, equal to pc_in while imem_req=1, else 0
//   imem_ack       : single-cycle pulse marking imem_rdata valid
//   imem_rdata     : instruction word returned by memory
//   redirect       : branch/jump redirect request
//   redirect_addr  : redirect target; forced to word alignment
//   inst           : fetched instruction to decode
//   inst_pc        : address of inst
//   inst_valid     : inst / inst_pc valid
//   inst_ready     : decode accepts inst this cycle
//   fetch_count    : number of instructions accepted by decode (mod 2^32)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        pc_load,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] fetch_count
);

    // IDLE : one quiet cycle after reset, then start fetching
    // REQ  : read outstanding at pc_in, waiting for the ack
    // HOLD : instruction captured, waiting for decode to accept it
    // DROP : a redirect squashed the outstanding read; swallow its ack
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        HOLD = 2'b10,
        DROP = 2'b11
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic [31:0] inst_r;
    logic [31:0] inst_pc_r;
    logic        inst_valid_r;
    logic [31:0] fetch_count_r;

    logic        pc_load_s;
    logic [31:0] pc_next_s;
    logic        imem_req_s;
    logic        capture_s;     // latch imem_rdata / pc_in for decode
    logic        release_s;     // held instruction leaves (accepted or squashed)
    logic        handshake_s;   // decode accepted the held instruction

    // Redirect targets are forced to a word boundary; masking keeps every
    // target bit in the expression so no input bit is left dangling.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Sequential PC; plain 32-bit addition wraps modulo 2^32.
    function automatic logic [31:0] pc_increment(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

    // Next-state decode plus the same-cycle PC load and memory request.
    always_comb begin
        state_next_s = state_r;
        pc_load_s    = 1'b0;
        pc_next_s    = 32'h0000_0000;
        imem_req_s   = 1'b0;
        capture_s    = 1'b0;
        release_s    = 1'b0;
        handshake_s  = 1'b0;

        case (state_r)
            IDLE: begin
                // Any stray ack here belongs to nothing we issued.
                state_next_s = REQ;
            end

            REQ: begin
                imem_req_s = 1'b1;
                if (redirect) begin
                    pc_load_s = 1'b1;
                    pc_next_s = align_word(redirect_addr);
                    // With the ack in the same cycle the read is already
                    // retired, so the new target can be requested directly.
                    if (imem_ack) begin
                        state_next_s = REQ;
                    end else begin
                        state_next_s = DROP;
                    end
                end else if (imem_ack) begin
                    pc_load_s    = 1'b1;
                    pc_next_s    = pc_increment(pc_in);
                    capture_s    = 1'b1;
                    state_next_s = HOLD;
                end else begin
                    state_next_s = REQ;
                end
            end

            HOLD: begin
                if (redirect) begin
                    // Squash the held word; it never counts as accepted.
                    pc_load_s    = 1'b1;
                    pc_next_s    = align_word(redirect_addr);
                    release_s    = 1'b1;
                    state_next_s = REQ;
                end else if (inst_ready) begin
                    handshake_s  = 1'b1;
                    release_s    = 1'b1;
                    state_next_s = REQ;
                end else begin
                    state_next_s = HOLD;
                end
            end

            DROP: begin
                if (redirect) begin
                    // The squashed read is still outstanding; keep waiting.
                    pc_load_s    = 1'b1;
                    pc_next_s    = align_word(redirect_addr);
                    state_next_s = DROP;
                end else if (imem_ack) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = DROP;
                end
            end

            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Instruction holding register presented to decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_r       <= 32'h0000_0000;
            inst_pc_r    <= 32'h0000_0000;
            inst_valid_r <= 1'b0;
        end else begin
            if (capture_s) begin
                inst_r       <= imem_rdata;
                inst_pc_r    <= pc_in;
                inst_valid_r <= 1'b1;
            end else if (release_s) begin
                inst_valid_r <= 1'b0;
            end else begin
                inst_valid_r <= inst_valid_r;
            end
        end
    end

    // Count of instructions accepted by decode; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_r <= 32'h0000_0000;
        end else begin
            if (handshake_s) begin
                fetch_count_r <= fetch_count_r + 32'd1;
            end else begin
                fetch_count_r <= fetch_count_r;
            end
        end
    end

    // pc_load/pc_next/imem_req must act in the ack cycle itself, so they are
    // decoded from the registered state rather than registered again; IDLE
    // (the reset state) drives them all to zero immediately on rst.
    assign pc_load     = pc_load_s;
    assign pc_next     = pc_next_s;
    assign imem_req    = imem_req_s;
    assign imem_addr   = imem_req_s ? pc_in : 32'h0000_0000;

    assign inst        = inst_r;
    assign inst_pc     = inst_pc_r;
    assign inst_valid  = inst_valid_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. The bench supplies the external PC register
// (loaded from pc_next when pc_load=1) and drives the memory ack by hand.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 time
// unit after that.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic        pc_load;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] fetch_count;

    int checks_total;
    int checks_passed;

    fetch_unit #(.PC_STEP(32'd4)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_in         (pc_reg),
        .pc_next       (pc_next),
        .pc_load       (pc_load),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg <= 32'h0000_0000;
        end else if (pc_load) begin
            pc_reg <= pc_next;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst           = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0000_0000;
        redirect      = 1'b0;
        redirect_addr = 32'h0000_0000;
        inst_ready    = 1'b0;
        #1 rst = 1'b1;
        tick();
        tick();

        // Reset state
        settle();
        chk("rst_imem_req",    {31'd0, imem_req},   32'h0);
        chk("rst_pc_load",     {31'd0, pc_load},    32'h0);
        chk("rst_pc_next",     pc_next,             32'h0);
        chk("rst_inst",        inst,                32'h0);
        chk("rst_inst_pc",     inst_pc,             32'h0);
        chk("rst_inst_valid",  {31'd0, inst_valid}, 32'h0);
        chk("rst_fetch_count", fetch_count,         32'h0);

        // Release reset: IDLE, a stray ack is ignored
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        settle();
        chk("idle_imem_req", {31'd0, imem_req}, 32'h0);
        chk("idle_pc_load",  {31'd0, pc_load},  32'h0);
        tick();
        imem_ack = 1'b0;

        // REQ at pc 0, ack one cycle later
        settle();
        chk("req0_imem_req",  {31'd0, imem_req},   32'h1);
        chk("req0_imem_addr", imem_addr,           32'h0);
        chk("req0_no_valid",  {31'd0, inst_valid}, 32'h0);
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h8C01_0004;
        inst_ready = 1'b1;
        settle();
        chk("ack0_pc_load", {31'd0, pc_load}, 32'h1);
        chk("ack0_pc_next", pc_next,          32'h4);
        tick();
        imem_ack = 1'b0;
        settle();
        chk("hold0_inst",       inst,                32'h8C01_0004);
        chk("hold0_inst_pc",    inst_pc,             32'h0);
        chk("hold0_inst_valid", {31'd0, inst_valid}, 32'h1);
        chk("hold0_imem_req",   {31'd0, imem_req},   32'h0);
        chk("hold0_pc",         pc_reg,              32'h4);
        tick();
        inst_ready = 1'b0;
        settle();
        chk("hs0_fetch_count", fetch_count,         32'h1);
        chk("hs0_inst_valid",  {31'd0, inst_valid}, 32'h0);

        // Ack delayed 3 cycles at pc 4
        for (int i = 0; i < 3; i++) begin
            chk("wait_imem_req",  {31'd0, imem_req}, 32'h1);
            chk("wait_imem_addr", imem_addr,         32'h4);
            chk("wait_pc_load",   {31'd0, pc_load},  32'h0);
            tick();
            settle();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_1111;
        settle();
        chk("ack1_pc_load", {31'd0, pc_load}, 32'h1);
        chk("ack1_pc_next", pc_next,          32'h8);
        tick();
        imem_ack = 1'b0;

        // HOLD with inst_ready low for 4 cycles
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("stall_inst",        inst,                32'h1111_1111);
            chk("stall_inst_pc",     inst_pc,             32'h4);
            chk("stall_inst_valid",  {31'd0, inst_valid}, 32'h1);
            chk("stall_imem_req",    {31'd0, imem_req},   32'h0);
            chk("stall_fetch_count", fetch_count,         32'h1);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        settle();
        chk("hs1_fetch_count", fetch_count, 32'h2);

        // Redirect to 0x103 while awaiting ack at pc 8 -> DROP
        chk("req2_imem_addr", imem_addr, 32'h8);
        redirect      = 1'b1;
        redirect_addr = 32'h0000_0103;
        settle();
        chk("rdr_req_pc_load", {31'd0, pc_load}, 32'h1);
        chk("rdr_req_pc_next", pc_next,          32'h100);
        tick();
        redirect = 1'b0;
        settle();
        chk("drop_imem_req", {31'd0, imem_req}, 32'h0);
        chk("drop_pc_load",  {31'd0, pc_load},  32'h0);
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        settle();
        chk("drop_ack_pc_load", {31'd0, pc_load}, 32'h0);
        tick();
        imem_ack = 1'b0;
        settle();
        chk("after_drop_imem_req",  {31'd0, imem_req},   32'h1);
        chk("after_drop_imem_addr", imem_addr,           32'h100);
        chk("after_drop_valid",     {31'd0, inst_valid}, 32'h0);
        chk("after_drop_inst",      inst,                32'h1111_1111);

        // Fetch at 0x100, then redirect in HOLD with inst_ready=1
        imem_ack   = 1'b1;
        imem_rdata = 32'h2222_2222;
        tick();
        imem_ack      = 1'b0;
        redirect      = 1'b1;
        redirect_addr = 32'h0000_0040;
        inst_ready    = 1'b1;
        settle();
        chk("rdr_hold_pc_load", {31'd0, pc_load}, 32'h1);
        chk("rdr_hold_pc_next", pc_next,          32'h40);
        tick();
        redirect   = 1'b0;
        inst_ready = 1'b0;
        settle();
        chk("rdr_hold_valid",       {31'd0, inst_valid}, 32'h0);
        chk("rdr_hold_fetch_count", fetch_count,         32'h2);
        chk("rdr_hold_imem_addr",   imem_addr,           32'h40);

        // Redirect together with ack in REQ -> data discarded, straight to REQ
        imem_ack      = 1'b1;
        imem_rdata    = 32'h3333_3333;
        redirect      = 1'b1;
        redirect_addr = 32'h0000_0080;
        settle();
        chk("rdr_ack_pc_next", pc_next, 32'h80);
        tick();
        imem_ack = 1'b0;
        redirect = 1'b0;
        settle();
        chk("rdr_ack_imem_req",  {31'd0, imem_req},   32'h1);
        chk("rdr_ack_imem_addr", imem_addr,           32'h80);
        chk("rdr_ack_valid",     {31'd0, inst_valid}, 32'h0);
        chk("rdr_ack_inst",      inst,                32'h2222_2222);

        // Redirect -> DROP, then redirect again inside DROP
        redirect      = 1'b1;
        redirect_addr = 32'h0000_0010;
        tick();
        redirect_addr = 32'hFFFF_FFFF;
        settle();
        chk("rdr_drop_pc_load", {31'd0, pc_load}, 32'h1);
        chk("rdr_drop_pc_next", pc_next,          32'hFFFF_FFFC);
        tick();
        redirect = 1'b0;
        settle();
        chk("rdr_drop_stays", {31'd0, imem_req}, 32'h0);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;

        // Fetch at 0xFFFFFFFC wraps the PC to 0
        settle();
        chk("wrap_imem_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack   = 1'b1;
        imem_rdata = 32'h4444_4444;
        settle();
        chk("wrap_pc_next", pc_next, 32'h0);
        tick();
        imem_ack   = 1'b0;
        inst_ready = 1'b1;
        settle();
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_pc",      pc_reg,  32'h0);
        tick();
        inst_ready = 1'b0;
        settle();
        chk("wrap_fetch_count", fetch_count, 32'h3);

        // Reset in the middle of a request
        chk("midreq_imem_req", {31'd0, imem_req}, 32'h1);
        rst = 1'b1;
        settle();
        chk("midrst_imem_req",    {31'd0, imem_req},   32'h0);
        chk("midrst_imem_addr",   imem_addr,           32'h0);
        chk("midrst_pc_load",     {31'd0, pc_load},    32'h0);
        chk("midrst_pc_next",     pc_next,             32'h0);
        chk("midrst_inst",        inst,                32'h0);
        chk("midrst_inst_pc",     inst_pc,             32'h0);
        chk("midrst_inst_valid",  {31'd0, inst_valid}, 32'h0);
        chk("midrst_fetch_count", fetch_count,         32'h0);
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_STEP, default 4, SHALL set the sequential PC increment in bytes.
REQ-002 clk  input  1  SHALL be the clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 pc_in  input  32  SHALL carry the current PC from the PC register output.
REQ-005 pc_next  output  32  SHALL carry the value the PC register loads when pc_load=1.
REQ-006 pc_load  output  1  SHALL strobe the PC register load enable.
REQ-007 imem_req  output  1  SHALL request an instruction-memory read.
REQ-008 imem_addr  output  32  SHALL carry the read address, equal to pc_in.
REQ-009 imem_ack  input  1  SHALL be a single-cycle pulse marking imem_rdata valid.
REQ-010 imem_rdata  input  32  SHALL carry the instruction word returned by memory.
REQ-011 redirect  input  1  SHALL request a branch/jump redirect.
REQ-012 redirect_addr  input  32  SHALL carry the redirect target.
REQ-013 inst  output  32  SHALL carry the fetched instruction to decode.
REQ-014 inst_pc  output  32  SHALL carry the address of inst.
REQ-015 inst_valid  output  1  SHALL mark inst and inst_pc valid.
REQ-016 inst_ready  input  1  SHALL indicate that decode accepts inst this cycle.
REQ-017 fetch_count  output  32  SHALL count accepted instructions.

Function
REQ-018 The FSM SHALL have four states: IDLE, REQ, HOLD, DROP.
REQ-019 IDLE: outputs inactive; the FSM SHALL go to REQ on the next edge unconditionally, and an imem_ack in IDLE SHALL be ignored.
REQ-020 REQ: imem_req=1 and imem_addr=pc_in; the FSM SHALL stay in REQ until imem_ack.
REQ-021 REQ with imem_ack and no redirect: inst<=imem_rdata, inst_pc<=pc_in, pc_load=1 and pc_next=pc_in+PC_STEP in the same cycle, and the FSM SHALL go to HOLD.
REQ-022 Latency: ack at cycle N SHALL give inst_valid=1 at cycle N+1, and the PC register SHALL hold the incremented value at cycle N+1.
REQ-023 HOLD: inst_valid=1 and imem_req=0; inst and inst_pc SHALL stay stable until inst_ready=1, after which the FSM SHALL go to REQ.
REQ-024 A handshake is inst_valid&inst_ready; each handshake SHALL increment fetch_count by 1, wrapping modulo 2^32.
REQ-025 pc_next SHALL use modulo-2^32 addition: 0xFFFFFFFC+4 -> 0x00000000.
REQ-026 Redirect (any state except IDLE) SHALL have priority over all other events: pc_load=1, pc_next={redirect_addr[31:2],2'b00} in that cycle.
REQ-027 Redirect in REQ without ack SHALL move the FSM to DROP; redirect in REQ with ack SHALL discard imem_rdata and move the FSM to REQ.
REQ-028 Redirect in HOLD SHALL drop the held instruction, leaving inst_valid=0 next cycle and fetch_count unchanged even if inst_ready=1, and SHALL move the FSM to REQ.
REQ-029 DROP: imem_req=0; the FSM SHALL stay in DROP until imem_ack, discard that data, then go to REQ.
REQ-030 Redirect in DROP SHALL reload the PC and keep the FSM in DROP.
REQ-031 pc_load SHALL be 0 in every cycle not covered by REQ-021 or REQ-026.
REQ-032 At most one request SHALL be outstanding at any time, and imem_req SHALL never be asserted in IDLE, HOLD or DROP.

Reset
REQ-033 rst=1 SHALL immediately force state=IDLE and inst=0, inst_pc=0, inst_valid=0, imem_req=0, pc_load=0, pc_next=0, fetch_count=0.
REQ-034 Reset mid-request SHALL abandon the request without waiting for ack; instruction memory SHALL be reset by the same rst.

Verification
REQ-035 Reset release with pc_in=0, 1-cycle ack latency, rdata=0x8C010004, inst_ready=1 -> inst=0x8C010004, inst_pc=0, then pc=4 and fetch_count=1.
REQ-036 Ack delayed 3 cycles -> imem_req held with imem_addr constant, pc_load=0 until ack.
REQ-037 inst_ready=0 for 4 cycles in HOLD -> inst stable, no new imem_req, fetch_count unchanged.
REQ-038 redirect to 0x00000103 while in REQ awaiting ack -> DROP, late ack data discarded, next imem_addr=0x00000100.
REQ-039 pc_in=0xFFFFFFFC fetch -> pc_next=0x00000000; rst asserted mid-REQ -> all outputs 0 in the same cycle.
